number_sequencer: RTL and testbench
===================================

Name: number_sequencer

Overview:
Upstream stage of the factorizer. Produces the 7-bit operand it consumes, from the input switches (manual load), from single-step button presses, or from a free-running auto-increment at a selectable rate. Debounces the buttons and emits a one-cycle valid pulse whenever the operand changes, so downstream display logic can latch the new factors.

Parameters:
WIDTH, 7, operand width; matches the factorizer input.
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button edge (>=2).
BASE_SHIFT, 18, auto-step period for rate_sel=0 is 2^BASE_SHIFT cycles.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sw_number  in  WIDTH  operand value from switches
load_btn  in  1  raw button: load sw_number
step_btn  in  1  raw button: increment operand
auto_en  in  1  raw switch: 1 = auto-increment mode
rate_sel  in  2  auto period = 2^(BASE_SHIFT + 2*rate_sel) cycles
hold  in  1  freezes operand and prescaler while high (already synchronous)
number  out  WIDTH  current operand, registered
number_valid  out  1  one-cycle pulse, high in the first cycle number shows a new value

Behaviour:
- Reset: number=0, number_valid=0, prescaler=0, all debouncers RELEASED, synchronisers cleared. Reset mid-press: button must be released and pressed again to register.
- load_btn, step_btn, auto_en pass through 2-flop synchronisers. sw_number is sampled unsynchronised at load time (static switches).
- Debouncer FSM, per button, on the synchronised level:
  - RELEASED -> ARMING on level=1, count=0.
  - ARMING: level=1 increments count. At count==DEBOUNCE_CYCLES-1 -> PRESSED and a one-cycle press pulse. level=0 -> RELEASED.
  - PRESSED -> DISARMING on level=0, count=0.
  - DISARMING: level=0 increments count. At count==DEBOUNCE_CYCLES-1 -> RELEASED. level=1 -> PRESSED, with no new pulse.
- Latency: raw button held high from edge E: the press pulse is high in cycle E+2+DEBOUNCE_CYCLES. number updates and number_valid is high in cycle E+3+DEBOUNCE_CYCLES.
- Update priority in one cycle: load press > step press > auto tick. Only one update per cycle; lower-priority events that cycle are dropped.
- Load: number <= sw_number. Prescaler cleared.
- Step: number <= number+1 modulo 2^WIDTH (127 -> 0). Accepted in both modes.
- Auto: prescaler runs only while synchronised auto_en=1 and hold=0. It is cleared when auto_en=0.
  - Tick when prescaler==period-1; prescaler returns to 0.
  - The first tick comes exactly period cycles after synchronised auto_en rises.
  - A rate_sel change takes effect immediately. If prescaler >= the new period-1, the next cycle ticks and the prescaler clears.
- hold=1: no updates of any kind, prescaler frozen, press pulses during hold are discarded. Debouncer FSMs keep running.
- number_valid fires on every accepted update, even when the value is unchanged (load of the same value).

Optional Feature:
SEQ_SKIP_TRIVIAL_EN.
- Defined: auto ticks and step presses skip operands 0 and 1; 127 wraps to 2, and an increment landing on 0 or 1 becomes 2. Loads are unaffected.
- Undefined: plain modulo-128 increment.

Decomposition:
- Package seq_pkg: localparam NUMBER_W=7; debounce state enum (RELEASED, ARMING, PRESSED, DISARMING); rate_sel encoding constants.
- Sub-module button_debounce (synchroniser + FSM + counter, outputs press pulse), instantiated for load_btn and step_btn.
- The auto_en synchroniser lives in the top.

Test Plan:
- Sim params DEBOUNCE_CYCLES=4, BASE_SHIFT=2.
- Reset: after rst, number=0 and number_valid=0. sw_number=45, load_btn high 10 cycles from edge E -> number=45 and number_valid=1 exactly at E+7, then valid=0.
- Bounce: load_btn toggles 1,0,1,0 on consecutive cycles, then stays 0 -> no valid pulse, number unchanged. Then held high 8 cycles -> exactly one pulse.
- Step wrap: load 126, two step presses -> number 127 then 0, one valid pulse each. With SEQ_SKIP_TRIVIAL_EN: 127 -> 2.
- Auto: auto_en=1, rate_sel=0 (period 4), hold=0 -> number increments every 4 cycles, first tick 4 cycles after synchronised auto_en rises. rate_sel=1 -> every 16 cycles. hold high 20 cycles -> no change, prescaler resumes from its frozen count.
- Priority: load and step press pulses in the same cycle with sw_number=9 -> number=9, single valid pulse. Load coinciding with an auto tick -> 9, and the next tick follows 4 cycles later.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the operand sequencer.
package seq_pkg;

  // Operand width consumed by the factorizer.
  localparam int unsigned NUMBER_W = 7;

  // Per-button debounce FSM states.
  typedef enum logic [1:0] {
    StReleased  = 2'd0,
    StArming    = 2'd1,
    StPressed   = 2'd2,
    StDisarming = 2'd3
  } deb_state_e;

  // rate_sel encodings: auto period = 2^(BASE_SHIFT + 2*rate_sel) cycles.
  localparam logic [1:0] RateX1  = 2'd0;
  localparam logic [1:0] RateX4  = 2'd1;
  localparam logic [1:0] RateX16 = 2'd2;
  localparam logic [1:0] RateX64 = 2'd3;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus debounce FSM for one raw button; emits a
// one-cycle press pulse when a debounced rising edge is accepted.
module button_debounce
  import seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CountLast = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, level_q;
  logic          vld1_q, vld2_q;
  logic          primed_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          count_done;

  assign count_done = (count_q == CountLast);

  // Synchroniser, priming flag and FSM state registers. A button held through
  // reset is ignored until the synchronised level has been seen low once.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      level_q  <= 1'b0;
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      primed_q <= 1'b0;
      state_q  <= StReleased;
      count_q  <= '0;
    end else begin
      sync1_q <= btn;
      level_q <= sync1_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
      if (vld2_q && !level_q) primed_q <= 1'b1;
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and stability counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StReleased: begin
        if (level_q && primed_q) begin
          state_d = StArming;
          count_d = '0;
        end
      end
      StArming: begin
        if (!level_q)        state_d = StReleased;
        else if (count_done) state_d = StPressed;
        else                 count_d = count_q + 1'b1;
      end
      StPressed: begin
        if (!level_q) begin
          state_d = StDisarming;
          count_d = '0;
        end
      end
      StDisarming: begin
        if (level_q)         state_d = StPressed;
        else if (count_done) state_d = StReleased;
        else                 count_d = count_q + 1'b1;
      end
      default: state_d = StReleased;
    endcase
  end

  // Press pulse in the cycle the arming run completes.
  always_comb begin
    press = (state_q == StArming) && level_q && count_done;
  end

endmodule

// File: rtl/number_sequencer.sv
// Operand sequencer feeding the factorizer: manual load from switches,
// debounced single-step, or auto-increment at a selectable rate.
// Optional build macro SEQ_SKIP_TRIVIAL_EN: increments skip operands 0 and 1.
module number_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH           = NUMBER_W,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned BASE_SHIFT      = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_number,
  input  logic             load_btn,
  input  logic             step_btn,
  input  logic             auto_en,
  input  logic [1:0]       rate_sel,
  input  logic             hold,
  output logic [WIDTH-1:0] number,
  output logic             number_valid
);

  // One spare bit so the longest period minus one is representable.
  localparam int unsigned PW = BASE_SHIFT + 7;
  localparam logic [PW-1:0] One = PW'(1);

  logic             load_press, step_press;
  logic             auto_s1_q, auto_q;
  logic [PW-1:0]    presc_q, presc_d, period_m1;
  logic [WIDTH-1:0] number_q, number_d, number_inc;
  logic             valid_q, valid_d;
  logic             tick;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (load_btn),
    .press(load_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (step_btn),
    .press(step_press)
  );

  // auto_en synchroniser, prescaler and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_s1_q <= 1'b0;
      auto_q    <= 1'b0;
      presc_q   <= '0;
      number_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      auto_s1_q <= auto_en;
      auto_q    <= auto_s1_q;
      presc_q   <= presc_d;
      number_q  <= number_d;
      valid_q   <= valid_d;
    end
  end

  // Auto period minus one for the current rate; a rate change applies at once.
  always_comb begin
    case (rate_sel)
      RateX1:  period_m1 = (One << BASE_SHIFT) - One;
      RateX4:  period_m1 = (One << (BASE_SHIFT + 2)) - One;
      RateX16: period_m1 = (One << (BASE_SHIFT + 4)) - One;
      RateX64: period_m1 = (One << (BASE_SHIFT + 6)) - One;
      default: period_m1 = (One << BASE_SHIFT) - One;
    endcase
  end

  // >= rather than == so a shortened period ticks immediately.
  assign tick = auto_q && !hold && (presc_q >= period_m1);

  // Successor operand for step presses and auto ticks.
  always_comb begin
    number_inc = number_q + 1'b1;
`ifdef SEQ_SKIP_TRIVIAL_EN
    if (number_inc < WIDTH'(2)) number_inc = WIDTH'(2);
`endif
  end

  // Update selection (load > step > tick) and prescaler next state.
  always_comb begin
    number_d = number_q;
    valid_d  = 1'b0;
    if (!hold) begin
      if (load_press) begin
        number_d = sw_number;
        valid_d  = 1'b1;
      end else if (step_press || tick) begin
        number_d = number_inc;
        valid_d  = 1'b1;
      end
    end
    presc_d = presc_q;
    if (!auto_q) begin
      presc_d = '0;
    end else if (!hold) begin
      if (load_press || tick) presc_d = '0;
      else                    presc_d = presc_q + 1'b1;
    end
  end

  assign number       = number_q;
  assign number_valid = valid_q;

endmodule

// File: tb/tb_number_sequencer.sv
// Self-checking bench for number_sequencer: directed scenarios plus random
// stimulus, all compared cycle by cycle against a behavioural model.
module tb_number_sequencer;

  localparam int DEB = 4;
  localparam int BS  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] sw_number;
  logic       load_btn, step_btn, auto_en, hold;
  logic [1:0] rate_sel;
  logic [6:0] number;
  logic       number_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;
  int vq[$];
  int t0;

  // Reference model state.
  logic [6:0] m_number;
  bit         m_valid;
  int         m_presc;
  bit         m_pressed[2];
  int         m_run[2];
  bit         m_primed[2];
  int         m_sv[2];
  bit         m_h0[2], m_h1[2];
  bit         m_a0, m_a1;

  number_sequencer #(
    .WIDTH(7),
    .DEBOUNCE_CYCLES(DEB),
    .BASE_SHIFT(BS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_number   (sw_number),
    .load_btn    (load_btn),
    .step_btn    (step_btn),
    .auto_en     (auto_en),
    .rate_sel    (rate_sel),
    .hold        (hold),
    .number      (number),
    .number_valid(number_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] m_inc(input logic [6:0] n);
    int r;
    r = (int'(n) + 1) % 128;
`ifdef SEQ_SKIP_TRIVIAL_EN
    if (r < 2) r = 2;
`endif
    return 7'(r);
  endfunction

  // Behavioural model: a button is accepted after DEB+1 consecutive cycles of
  // a synchronised level differing from the debounced one.
  always @(posedge clk) begin : ref_model
    bit raw[2];
    bit lv, tick;
    bit pulse[2];
    int period;
    if (rst) begin
      m_number = '0; m_valid = 0; m_presc = 0; m_a0 = 0; m_a1 = 0;
      for (int b = 0; b < 2; b++) begin
        m_pressed[b] = 0; m_run[b] = 0; m_primed[b] = 0; m_sv[b] = 0;
        m_h0[b] = 0; m_h1[b] = 0;
      end
    end else begin
      raw[0] = load_btn;
      raw[1] = step_btn;
      for (int b = 0; b < 2; b++) begin
        lv = m_h1[b];
        pulse[b] = 0;
        if (lv != m_pressed[b] && (m_pressed[b] || m_primed[b])) begin
          m_run[b]++;
          if (m_run[b] == DEB + 1) begin
            m_pressed[b] = lv;
            m_run[b] = 0;
            pulse[b] = lv;
          end
        end else begin
          m_run[b] = 0;
        end
        if (m_sv[b] == 2 && !lv) m_primed[b] = 1;
        m_h1[b] = m_h0[b];
        m_h0[b] = raw[b];
        if (m_sv[b] < 2) m_sv[b]++;
      end
      period = 1 << (BS + 2 * int'(rate_sel));
      tick = m_a1 && !hold && (m_presc >= period - 1);
      m_valid = 0;
      if (!hold) begin
        if (pulse[0]) begin
          m_number = sw_number; m_valid = 1;
        end else if (pulse[1] || tick) begin
          m_number = m_inc(m_number); m_valid = 1;
        end
      end
      if (!m_a1) m_presc = 0;
      else if (!hold) m_presc = (pulse[0] || tick) ? 0 : m_presc + 1;
      m_a1 = m_a0;
      m_a0 = auto_en;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n cycles, comparing against the model at each falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc_no++;
      check_eq("number", 32'(number), 32'(m_number));
      check_eq("valid", 32'(number_valid), 32'(m_valid));
      if (number_valid) vq.push_back(cyc_no);
    end
  endtask

  task automatic press(input bit ld, input bit st, input int hi, input int lo);
    load_btn = ld;
    step_btn = st;
    cyc(hi);
    load_btn = 1'b0;
    step_btn = 1'b0;
    cyc(lo);
  endtask

  initial begin
    rst = 1'b1; sw_number = '0; load_btn = 0; step_btn = 0;
    auto_en = 0; hold = 0; rate_sel = 2'd0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check_eq("rst_number", 32'(number), 0);
    check_eq("rst_valid", 32'(number_valid), 0);
    cyc(4);

    // Load 45: pulse visible exactly 7 cycles after the raw edge.
    sw_number = 7'd45;
    vq.delete();
    t0 = cyc_no;
    press(1, 0, 10, 10);
    check_eq("load_cnt", vq.size(), 1);
    if (vq.size() > 0) check_eq("load_lat", vq[0] - t0, 7);
    check_eq("load_val", 32'(number), 45);

    // Bounce is rejected, then a clean hold reloads the same value.
    vq.delete();
    sw_number = 7'd100;
    for (int i = 0; i < 4; i++) begin
      load_btn = (i % 2 == 0);
      cyc(1);
    end
    load_btn = 0;
    cyc(12);
    check_eq("bounce_cnt", vq.size(), 0);
    check_eq("bounce_val", 32'(number), 45);
    sw_number = 7'd45;
    press(1, 0, 8, 10);
    check_eq("hold8_cnt", vq.size(), 1);

    // Step wrap.
    sw_number = 7'd126;
    press(1, 0, 7, 9);
    vq.delete();
    press(0, 1, 7, 9);
    check_eq("step1", 32'(number), 127);
    press(0, 1, 7, 9);
`ifdef SEQ_SKIP_TRIVIAL_EN
    check_eq("step2", 32'(number), 2);
`else
    check_eq("step2", 32'(number), 0);
`endif
    check_eq("step_cnt", vq.size(), 2);

    // Auto at rate 0 (period 4).
    vq.delete();
    t0 = cyc_no;
    auto_en = 1'b1;
    cyc(30);
    check_eq("auto_enough", 32'(vq.size() >= 3), 1);
    if (vq.size() >= 3) begin
      check_eq("auto_first", vq[0] - t0, 6);
      check_eq("auto_gap1", vq[1] - vq[0], 4);
      check_eq("auto_gap2", vq[2] - vq[1], 4);
    end
    rate_sel = 2'd1;
    vq.delete();
    cyc(60);
    check_eq("rate1_enough", 32'(vq.size() >= 3), 1);
    if (vq.size() >= 3) check_eq("rate1_gap", vq[2] - vq[1], 16);
    hold = 1'b1;
    vq.delete();
    cyc(20);
    check_eq("hold_cnt", vq.size(), 0);
    hold = 1'b0;
    cyc(20);
    auto_en = 1'b0;
    rate_sel = 2'd0;
    cyc(4);

    // Simultaneous load and step presses: load wins, one pulse.
    sw_number = 7'd9;
    vq.delete();
    press(1, 1, 8, 10);
    check_eq("prio_cnt", vq.size(), 1);
    check_eq("prio_val", 32'(number), 9);

    // Button held through reset is ignored until released.
    sw_number = 7'd77;
    load_btn = 1'b1;
    cyc(10);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    vq.delete();
    cyc(12);
    check_eq("rstpress_cnt", vq.size(), 0);
    check_eq("rstpress_val", 32'(number), 0);
    load_btn = 1'b0;
    cyc(9);
    press(1, 0, 8, 10);
    check_eq("repress_val", 32'(number), 77);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      sw_number = 7'($urandom);
      if ($urandom_range(0, 9) == 0) load_btn = ~load_btn;
      if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 79) == 0) rate_sel = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      rst = ($urandom_range(0, 799) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
